// File: rtl/imem_loader.sv
//------------------------------------------------------------------------------
// imem_loader : boot loader that writes a framed byte-stream image into IMEM
//               and holds the core in reset until the image is complete.
// Option      : IMEM_LOADER_CSUM_EN adds a trailing XOR checksum byte.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  output logic              o_rx_ready,
  input  logic              i_restart,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_core_rst_n,
  output logic              o_done,
  output logic              o_error
);

  localparam logic [16:0] c_CAP = 17'd1 << ADDR_W;

`ifdef IMEM_LOADER_CSUM_EN
  typedef enum logic [2:0] {
    S_CNT_LO = 3'd0,
    S_CNT_HI = 3'd1,
    S_DATA   = 3'd2,
    S_CSUM   = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_CNT_LO = 3'd0,
    S_CNT_HI = 3'd1,
    S_DATA   = 3'd2,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;
`endif

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_armed;
  logic [15:0]       r_cnt;
  logic [1:0]        r_byte_idx;
  logic [ADDR_W:0]   r_word_idx;
  logic [23:0]       r_wbuf;
  logic              r_imem_we;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [31:0]       r_imem_wdata;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]        r_csum;
`endif

  logic              w_ready;
  logic              w_xfer;
  logic [15:0]       w_cnt_full;
  logic              w_cnt_bad;
  logic [ADDR_W:0]   w_word_inc;
  logic              w_last_word;

  assign w_ready = r_armed & ((r_state == S_CNT_LO) | (r_state == S_CNT_HI) |
`ifdef IMEM_LOADER_CSUM_EN
                              (r_state == S_CSUM) |
`endif
                              (r_state == S_DATA));
  assign w_xfer      = i_rx_valid & w_ready;
  assign w_cnt_full  = {i_rx_data, r_cnt[7:0]};
  assign w_cnt_bad   = (w_cnt_full == 16'd0) || ({1'b0, w_cnt_full} > c_CAP);
  assign w_word_inc  = r_word_idx + 1'b1;
  // word_idx carries one extra bit so a full-capacity image ends cleanly
  assign w_last_word = (17'(w_word_inc) == {1'b0, r_cnt});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_CNT_LO;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    o_rx_ready   = w_ready;
    o_done       = (r_state == S_DONE);
    o_error      = (r_state == S_ERR);
    o_core_rst_n = (r_state == S_DONE);
    if (i_restart) begin
      w_state_nxt = S_CNT_LO;
    end else if (w_xfer) begin
      case (r_state)
        S_CNT_LO: w_state_nxt = S_CNT_HI;
        S_CNT_HI: w_state_nxt = w_cnt_bad ? S_ERR : S_DATA;
        S_DATA: begin
          if ((r_byte_idx == 2'd3) && w_last_word) begin
`ifdef IMEM_LOADER_CSUM_EN
            w_state_nxt = S_CSUM;
`else
            w_state_nxt = S_DONE;
`endif
          end
        end
`ifdef IMEM_LOADER_CSUM_EN
        S_CSUM:   w_state_nxt = (i_rx_data == r_csum) ? S_DONE : S_ERR;
`endif
        default:  w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_armed      <= 1'b0;
      r_cnt        <= '0;
      r_byte_idx   <= '0;
      r_word_idx   <= '0;
      r_wbuf       <= '0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      r_armed   <= 1'b1;
      r_imem_we <= 1'b0;
      if (i_restart) begin
        r_cnt      <= '0;
        r_byte_idx <= '0;
        r_word_idx <= '0;
`ifdef IMEM_LOADER_CSUM_EN
        r_csum     <= '0;
`endif
      end else if (w_xfer) begin
        case (r_state)
          S_CNT_LO: begin
            r_cnt[7:0] <= i_rx_data;
`ifdef IMEM_LOADER_CSUM_EN
            r_csum     <= i_rx_data;
`endif
          end
          S_CNT_HI: begin
            r_cnt[15:8] <= i_rx_data;
            r_byte_idx  <= '0;
            r_word_idx  <= '0;
`ifdef IMEM_LOADER_CSUM_EN
            r_csum      <= r_csum ^ i_rx_data;
`endif
          end
          S_DATA: begin
            r_byte_idx <= r_byte_idx + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
            r_csum     <= r_csum ^ i_rx_data;
`endif
            case (r_byte_idx)
              2'd0: r_wbuf[7:0]   <= i_rx_data;
              2'd1: r_wbuf[15:8]  <= i_rx_data;
              2'd2: r_wbuf[23:16] <= i_rx_data;
              default: begin
                r_imem_wdata <= {i_rx_data, r_wbuf};
                r_imem_addr  <= r_word_idx[ADDR_W-1:0];
                r_imem_we    <= 1'b1;
                r_word_idx   <= w_word_inc;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign o_imem_we    = r_imem_we;
  assign o_imem_addr  = r_imem_addr;
  assign o_imem_wdata = r_imem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
//------------------------------------------------------------------------------
// tb_imem_loader : directed-stream bench with a frame-position reference model.
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_imem_loader;

  localparam int ADDR_W = 8;
`ifdef IMEM_LOADER_CSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  typedef logic [7:0] byte_q_t[$];

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_rx_valid = 1'b0;
  logic [7:0]        i_rx_data = 8'h00;
  logic              i_restart = 1'b0;
  logic              o_rx_ready;
  logic              o_imem_we;
  logic [ADDR_W-1:0] o_imem_addr;
  logic [31:0]       o_imem_wdata;
  logic              o_core_rst_n;
  logic              o_done;
  logic              o_error;

  int checks = 0;
  int errors = 0;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_rx_valid   (i_rx_valid),
    .i_rx_data    (i_rx_data),
    .o_rx_ready   (o_rx_ready),
    .i_restart    (i_restart),
    .o_imem_we    (o_imem_we),
    .o_imem_addr  (o_imem_addr),
    .o_imem_wdata (o_imem_wdata),
    .o_core_rst_n (o_core_rst_n),
    .o_done       (o_done),
    .o_error      (o_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the position within the frame, not FSM states
  bit                m_armed;
  int                m_pos;
  int                m_n;
  int                m_status;   // 0 loading, 1 done, 2 error
  int                m_k;
  logic [7:0]        m_lo;
  logic [7:0]        m_csum;
  logic [7:0]        m_b [4];
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_data;
  bit                m_rdy;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_armed = 1'b0; m_pos = 0; m_n = 0; m_status = 0; m_lo = 8'h00;
      m_csum = 8'h00; m_we = 1'b0; m_addr = '0; m_data = 32'h0;
    end else begin
      m_rdy = m_armed && (m_status == 0);
      m_we  = 1'b0;
      if (i_restart) begin
        m_pos = 0; m_status = 0; m_csum = 8'h00;
      end else if (i_rx_valid && m_rdy) begin
        if (m_pos == 0) begin
          m_lo = i_rx_data; m_csum = i_rx_data;
        end else if (m_pos == 1) begin
          m_n = {i_rx_data, m_lo};
          m_csum = m_csum ^ i_rx_data;
          if (m_n == 0 || m_n > (1 << ADDR_W)) m_status = 2;
        end else if (m_pos - 2 < 4 * m_n) begin
          m_k = m_pos - 2;
          m_csum = m_csum ^ i_rx_data;
          m_b[m_k % 4] = i_rx_data;
          if (m_k % 4 == 3) begin
            m_we = 1'b1;
            m_addr = ADDR_W'(m_k / 4);
            m_data = {m_b[3], m_b[2], m_b[1], m_b[0]};
          end
          if (m_k == 4 * m_n - 1 && !CS_EN) m_status = 1;
        end else begin
          m_status = (i_rx_data == m_csum) ? 1 : 2;
        end
        m_pos++;
      end
      m_armed = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rx_ready",   o_rx_ready,   m_rdy_now());
      chk("imem_we",    o_imem_we,    m_we);
      chk("imem_addr",  o_imem_addr,  m_addr);
      chk("imem_wdata", o_imem_wdata, m_data);
      chk("done",       o_done,       m_status == 1);
      chk("error",      o_error,      m_status == 2);
      chk("core_rst_n", o_core_rst_n, m_status == 1);
    end
  end

  function automatic logic m_rdy_now();
    return m_armed && (m_status == 0);
  endfunction

  logic [ADDR_W-1:0] wlog_a[$];
  logic [31:0]       wlog_d[$];

  always @(negedge clk) begin
    if (rst && o_imem_we) begin
      wlog_a.push_back(o_imem_addr);
      wlog_d.push_back(o_imem_wdata);
    end
  end

  function automatic logic [7:0] xsum(input byte_q_t q);
    logic [7:0] s = 8'h00;
    foreach (q[i]) s = s ^ q[i];
    return s;
  endfunction

  task automatic send(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    while (!o_rx_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!o_rx_ready) chk("accept_timeout", o_rx_ready, 1);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    i_rx_valid = 1'b0;
    i_rx_data  = 8'hEE;
    repeat (n) @(posedge clk);
  endtask

  task automatic send_stream(input byte_q_t q, input int gap);
    foreach (q[i]) begin
      send(q[i]);
      if (gap > 0) idle(gap);
    end
    idle(2);
  endtask

  task automatic offer(input logic [7:0] b, input int n);
    @(negedge clk);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    repeat (n) @(negedge clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic do_restart(input logic with_byte, input logic [7:0] b);
    @(negedge clk);
    i_restart  = 1'b1;
    i_rx_valid = with_byte;
    i_rx_data  = b;
    @(negedge clk);
    i_restart  = 1'b0;
    i_rx_valid = 1'b0;
    wlog_a.delete();
    wlog_d.delete();
  endtask

  task automatic chk_basic(input string tag);
    chk({tag, "_nwrites"}, wlog_a.size(), 2);
    if (wlog_a.size() == 2) begin
      chk({tag, "_addr0"}, wlog_a[0], 0);
      chk({tag, "_data0"}, wlog_d[0], 32'h00000013);
      chk({tag, "_addr1"}, wlog_a[1], 1);
      chk({tag, "_data1"}, wlog_d[1], 32'h00500093);
    end
    chk({tag, "_done"},       o_done,       1);
    chk({tag, "_core_rst_n"}, o_core_rst_n, 1);
    chk({tag, "_error"},      o_error,      0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t basic, q;
    basic = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00};
    if (CS_EN) basic.push_back(xsum(basic));

    // Reset values
    #2 rst = 1'b0;
    #1;
    chk("rst_ready", o_rx_ready, 0);   chk("rst_we", o_imem_we, 0);
    chk("rst_addr", o_imem_addr, 0);   chk("rst_wdata", o_imem_wdata, 0);
    chk("rst_core", o_core_rst_n, 0);  chk("rst_done", o_done, 0);
    chk("rst_error", o_error, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    #1 chk("ready_before_arm", o_rx_ready, 0);
    @(negedge clk);
    chk("ready_after_arm", o_rx_ready, 1);

    // Basic load, then an extra byte must be refused
    send_stream(basic, 0);
    chk_basic("basic");
    offer(8'hAA, 3);
    chk("basic_extra_nwrites", wlog_a.size(), 2);
    chk("basic_extra_ready", o_rx_ready, 0);

    // Bad checksum
    if (CS_EN) begin
      do_restart(1'b0, 8'h00);
      q = basic;
      q[q.size()-1] = q[q.size()-1] ^ 8'h01;
      send_stream(q, 0);
      chk("badcs_nwrites", wlog_a.size(), 2);
      chk("badcs_error", o_error, 1);
      chk("badcs_done", o_done, 0);
      chk("badcs_core", o_core_rst_n, 0);
    end

    // Illegal counts
    do_restart(1'b0, 8'h00);
    q = '{8'h00, 8'h00};
    send_stream(q, 0);
    chk("cnt0_error", o_error, 1);
    chk("cnt0_ready", o_rx_ready, 0);
    chk("cnt0_nwrites", wlog_a.size(), 0);
    do_restart(1'b0, 8'h00);
    q = '{8'h01, 8'h01};
    send_stream(q, 0);
    chk("cnt257_error", o_error, 1);
    chk("cnt257_ready", o_rx_ready, 0);
    chk("cnt257_nwrites", wlog_a.size(), 0);

    // Gapped stream
    do_restart(1'b0, 8'h00);
    send_stream(basic, 2);
    chk_basic("gaps");

    // Full capacity
    do_restart(1'b0, 8'h00);
    q = '{8'h00, 8'h01};
    for (int i = 0; i < 1024; i++) q.push_back(8'(i));
    if (CS_EN) q.push_back(xsum(q));
    send_stream(q, 0);
    chk("full_nwrites", wlog_a.size(), 256);
    if (wlog_a.size() == 256) begin
      chk("full_last_addr", wlog_a[255], 8'hFF);
      chk("full_last_data", wlog_d[255], 32'hFFFEFDFC);
      chk("full_first_data", wlog_d[0], 32'h03020100);
    end
    chk("full_done", o_done, 1);
    offer(8'h55, 3);
    chk("full_extra_ready", o_rx_ready, 0);
    chk("full_extra_nwrites", wlog_a.size(), 256);

    // Restart after five payload bytes with a coincident byte
    do_restart(1'b0, 8'h00);
    for (int i = 0; i < 7; i++) send(basic[i]);
    do_restart(1'b1, 8'h77);
    chk("rs_ready", o_rx_ready, 1);
    chk("rs_done", o_done, 0);
    chk("rs_error", o_error, 0);
    send_stream(basic, 0);
    chk_basic("after_restart");

    // Asynchronous reset mid-word
    do_restart(1'b0, 8'h00);
    for (int i = 0; i < 4; i++) send(basic[i]);
    @(negedge clk);
    i_rx_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_ready", o_rx_ready, 0);   chk("arst_we", o_imem_we, 0);
    chk("arst_addr", o_imem_addr, 0);   chk("arst_wdata", o_imem_wdata, 0);
    chk("arst_core", o_core_rst_n, 0);  chk("arst_done", o_done, 0);
    chk("arst_error", o_error, 0);
    @(negedge clk);
    rst = 1'b1;
    wlog_a.delete();
    wlog_d.delete();
    @(negedge clk);
    chk("arst_rearm", o_rx_ready, 1);
    send_stream(basic, 0);
    chk_basic("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
